// File: rtl/code_lock.sv
// code_lock: sequential combination lock.
// A keypad presents a CODE_LEN-symbol code one symbol per strobe. The entry is
// compared against a programmable stored code. A correct entry opens the lock
// for OPEN_CYC cycles. MAX_FAIL consecutive wrong entries cause a lockout that
// lasts LOCKOUT_CYC cycles. The code can be reloaded only while the lock is open.
//
// state     | meaning
// ----------+-------------------------------------------------
// S_IDLE    | no symbols entered
// S_ENTRY   | 1 to CODE_LEN-1 symbols entered
// S_OPEN    | lock released, timer counting down
// S_LOCKOUT | input refused, timer counting down
module code_lock #(
    parameter int                         SYM_W       = 4,
    parameter int                         CODE_LEN    = 4,
    parameter int                         MAX_FAIL    = 3,
    parameter int                         OPEN_CYC    = 8,
    parameter int                         LOCKOUT_CYC = 16,
    parameter logic [SYM_W*CODE_LEN-1:0]  RESET_CODE  = 16'h4321,
    localparam int                        CNT_W       = $clog2(CODE_LEN + 1)
) (
    input  logic                        i_clk,
    input  logic                        i_reset,
    input  logic                        i_sym_valid,
    input  logic [SYM_W-1:0]            i_sym,
    input  logic                        i_clear,
    input  logic                        i_code_load,
    input  logic [SYM_W*CODE_LEN-1:0]   i_code_in,
    output logic                        o_lock_open,
    output logic                        o_lockout,
    output logic                        o_fail,
    output logic [CNT_W-1:0]            o_entry_cnt
);

    localparam int FAIL_W  = $clog2(MAX_FAIL + 1);
    localparam int MAX_CYC = (OPEN_CYC > LOCKOUT_CYC) ? OPEN_CYC : LOCKOUT_CYC;
    localparam int TMR_W   = $clog2(MAX_CYC + 1);

    localparam logic [CNT_W-1:0]  IDX_LAST = CNT_W'(CODE_LEN - 1);
    localparam logic [CNT_W-1:0]  IDX_ONE  = CNT_W'(1);
    localparam logic [FAIL_W-1:0] FAIL_LIM = FAIL_W'(MAX_FAIL);
    localparam logic [FAIL_W-1:0] FAIL_ONE = FAIL_W'(1);
    localparam logic [TMR_W-1:0]  OPEN_LD  = TMR_W'(OPEN_CYC);
    localparam logic [TMR_W-1:0]  LOCK_LD  = TMR_W'(LOCKOUT_CYC);
    localparam logic [TMR_W-1:0]  TMR_ONE  = TMR_W'(1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ENTRY,
        S_OPEN,
        S_LOCKOUT
    } state_t;

    state_t                       r_state;
    logic [CNT_W-1:0]             r_idx;
    logic                         r_mismatch;
    logic [FAIL_W-1:0]            r_fail_cnt;
    logic [TMR_W-1:0]             r_timer;
    logic [SYM_W*CODE_LEN-1:0]    r_code;
    logic                         r_fail;

    state_t                       w_state_nxt;
    logic [CNT_W-1:0]             w_idx_nxt;
    logic                         w_mismatch_nxt;
    logic [FAIL_W-1:0]            w_fail_cnt_nxt;
    logic [TMR_W-1:0]             w_timer_nxt;
    logic [SYM_W*CODE_LEN-1:0]    w_code_nxt;
    logic                         w_fail_nxt;

    logic [SYM_W-1:0]             w_code_sym;
    logic                         w_mis_acc;
    logic [FAIL_W-1:0]            w_fail_inc;

    // Select the stored symbol expected at the current entry position.
    always_comb begin
        w_code_sym = '0;
        for (int k = 0; k < CODE_LEN; k++) begin
            if (r_idx == CNT_W'(k)) begin
                w_code_sym = r_code[k*SYM_W +: SYM_W];
            end
        end
    end

    // Mismatch including the symbol being accepted this cycle.
    assign w_mis_acc  = r_mismatch | (i_sym != w_code_sym);
    assign w_fail_inc = r_fail_cnt + FAIL_ONE;

    // Next-state and next-register logic.
    always_comb begin
        w_state_nxt    = r_state;
        w_idx_nxt      = r_idx;
        w_mismatch_nxt = r_mismatch;
        w_fail_cnt_nxt = r_fail_cnt;
        w_timer_nxt    = r_timer;
        w_code_nxt     = r_code;
        w_fail_nxt     = 1'b0;

        case (r_state)
            S_IDLE, S_ENTRY: begin
                if (i_clear) begin
                    w_state_nxt    = S_IDLE;
                    w_idx_nxt      = '0;
                    w_mismatch_nxt = 1'b0;
                end else if (i_sym_valid) begin
                    if (r_idx == IDX_LAST) begin
                        w_idx_nxt      = '0;
                        w_mismatch_nxt = 1'b0;
                        if (!w_mis_acc) begin
                            w_state_nxt    = S_OPEN;
                            w_timer_nxt    = OPEN_LD;
                            w_fail_cnt_nxt = '0;
                        end else begin
                            w_fail_nxt = 1'b1;
                            if (w_fail_inc == FAIL_LIM) begin
                                w_state_nxt    = S_LOCKOUT;
                                w_timer_nxt    = LOCK_LD;
                                w_fail_cnt_nxt = '0;
                            end else begin
                                w_state_nxt    = S_IDLE;
                                w_fail_cnt_nxt = w_fail_inc;
                            end
                        end
                    end else begin
                        w_state_nxt    = S_ENTRY;
                        w_idx_nxt      = r_idx + IDX_ONE;
                        w_mismatch_nxt = w_mis_acc;
                    end
                end
            end
            S_OPEN: begin
                // A load together with clear still takes the new code.
                if (i_code_load) begin
                    w_code_nxt = i_code_in;
                end
                if (i_clear || (r_timer == TMR_ONE)) begin
                    w_state_nxt = S_IDLE;
                    w_timer_nxt = '0;
                end else begin
                    w_timer_nxt = r_timer - TMR_ONE;
                end
            end
            S_LOCKOUT: begin
                if (r_timer == TMR_ONE) begin
                    w_state_nxt = S_IDLE;
                    w_timer_nxt = '0;
                end else begin
                    w_timer_nxt = r_timer - TMR_ONE;
                end
            end
            default: begin
                w_state_nxt    = S_IDLE;
                w_idx_nxt      = '0;
                w_mismatch_nxt = 1'b0;
                w_timer_nxt    = '0;
            end
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state    <= S_IDLE;
            r_idx      <= '0;
            r_mismatch <= 1'b0;
            r_fail_cnt <= '0;
            r_timer    <= '0;
            r_code     <= RESET_CODE;
            r_fail     <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_idx      <= w_idx_nxt;
            r_mismatch <= w_mismatch_nxt;
            r_fail_cnt <= w_fail_cnt_nxt;
            r_timer    <= w_timer_nxt;
            r_code     <= w_code_nxt;
            r_fail     <= w_fail_nxt;
        end
    end

    assign o_lock_open = (r_state == S_OPEN);
    assign o_lockout   = (r_state == S_LOCKOUT);
    assign o_fail      = r_fail;
    assign o_entry_cnt = r_idx;

endmodule

// File: tb/tb_code_lock.sv
// Testbench for code_lock with default parameters.
module tb_code_lock;

    logic        clk = 1'b0;
    logic        reset;
    logic        sym_valid;
    logic [3:0]  sym;
    logic        clear;
    logic        code_load;
    logic [15:0] code_in;
    logic        lock_open;
    logic        lockout;
    logic        fail;
    logic [2:0]  entry_cnt;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic        v;
        logic [3:0]  s;
        logic        c;
        logic        l;
        logic [15:0] ci;
        logic        eo;
        logic        el;
        logic        ef;
        logic [2:0]  ec;
    } vec_t;

    vec_t tbl[$];

    code_lock dut (
        .i_clk       (clk),
        .i_reset     (reset),
        .i_sym_valid (sym_valid),
        .i_sym       (sym),
        .i_clear     (clear),
        .i_code_load (code_load),
        .i_code_in   (code_in),
        .o_lock_open (lock_open),
        .o_lockout   (lockout),
        .o_fail      (fail),
        .o_entry_cnt (entry_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic eo, input logic el,
                       input logic ef, input logic [2:0] ec);
        checks++;
        if (lock_open !== eo || lockout !== el || fail !== ef || entry_cnt !== ec) begin
            errors++;
            $display("FAIL %s @%0t: got open=%0b lockout=%0b fail=%0b cnt=%0d, expected open=%0b lockout=%0b fail=%0b cnt=%0d",
                     name, $time, lock_open, lockout, fail, entry_cnt, eo, el, ef, ec);
        end
    endtask

    task automatic step(input logic v, input logic [3:0] s, input logic c,
                        input logic l, input logic [15:0] ci);
        @(negedge clk);
        sym_valid = v;
        sym       = s;
        clear     = c;
        code_load = l;
        code_in   = ci;
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        step(1'b0, 4'd0, 1'b0, 1'b0, 16'h0);
    endtask

    task automatic sym_in(input logic [3:0] s);
        step(1'b1, s, 1'b0, 1'b0, 16'h0);
    endtask

    // First three symbols of an entry, checking the count and no fail pulse.
    task automatic enter3(input string name, input logic [3:0] a,
                          input logic [3:0] b, input logic [3:0] c);
        sym_in(a); chk(name, 1'b0, 1'b0, 1'b0, 3'd1);
        sym_in(b); chk(name, 1'b0, 1'b0, 1'b0, 3'd2);
        sym_in(c); chk(name, 1'b0, 1'b0, 1'b0, 3'd3);
    endtask

    // Asynchronous reset between clock edges; outputs must drop without an edge.
    task automatic async_reset(input string name);
        #2;
        reset = 1'b1;
        #1;
        chk(name, 1'b0, 1'b0, 1'b0, 3'd0);
        sym_valid = 1'b0;
        clear     = 1'b0;
        code_load = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic add(input logic v, input logic [3:0] s, input logic c, input logic l,
                       input logic [15:0] ci, input logic eo, input logic el,
                       input logic ef, input logic [2:0] ec);
        vec_t t;
        t.v = v; t.s = s; t.c = c; t.l = l; t.ci = ci;
        t.eo = eo; t.el = el; t.ef = ef; t.ec = ec;
        tbl.push_back(t);
    endtask

    initial begin
        // correct entry 1,2,3,4 then open for exactly 8 cycles
        add(1, 4'd1, 0, 0, 16'h0, 0, 0, 0, 3'd1);
        add(1, 4'd2, 0, 0, 16'h0, 0, 0, 0, 3'd2);
        add(1, 4'd3, 0, 0, 16'h0, 0, 0, 0, 3'd3);
        add(1, 4'd4, 0, 0, 16'h0, 1, 0, 0, 3'd0);
        for (int i = 0; i < 7; i++) add(0, 4'd0, 0, 0, 16'h0, 1, 0, 0, 3'd0);
        add(0, 4'd0, 0, 0, 16'h0, 0, 0, 0, 3'd0);
        // clear with simultaneous sym_valid abandons the entry
        add(1, 4'd1, 0, 0, 16'h0, 0, 0, 0, 3'd1);
        add(1, 4'd2, 0, 0, 16'h0, 0, 0, 0, 3'd2);
        add(1, 4'd3, 1, 0, 16'h0, 0, 0, 0, 3'd0);
        // code_load outside OPEN has no effect
        add(0, 4'd0, 0, 1, 16'h1111, 0, 0, 0, 3'd0);
        add(1, 4'd1, 0, 0, 16'h0, 0, 0, 0, 3'd1);
        add(1, 4'd2, 0, 0, 16'h0, 0, 0, 0, 3'd2);
        add(1, 4'd3, 0, 0, 16'h0, 0, 0, 0, 3'd3);
        add(1, 4'd4, 0, 0, 16'h0, 1, 0, 0, 3'd0);
        // symbols ignored while open, clear relocks
        add(1, 4'd1, 0, 0, 16'h0, 1, 0, 0, 3'd0);
        add(0, 4'd0, 1, 0, 16'h0, 0, 0, 0, 3'd0);

        reset     = 1'b1;
        sym_valid = 1'b0;
        sym       = 4'd0;
        clear     = 1'b0;
        code_load = 1'b0;
        code_in   = 16'h0;
        #1;
        chk("reset_state", 1'b0, 1'b0, 1'b0, 3'd0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        chk("after_reset", 1'b0, 1'b0, 1'b0, 3'd0);

        foreach (tbl[i]) begin
            step(tbl[i].v, tbl[i].s, tbl[i].c, tbl[i].l, tbl[i].ci);
            chk($sformatf("vec%0d", i), tbl[i].eo, tbl[i].el, tbl[i].ef, tbl[i].ec);
        end

        // three wrong entries -> lockout for 16 cycles
        for (int n = 1; n <= 3; n++) begin
            enter3("wrong_prefix", 4'd1, 4'd2, 4'd3);
            sym_in(4'd5);
            chk("wrong_final", 1'b0, (n == 3), 1'b1, 3'd0);
        end
        sym_in(4'd1); chk("lockout_ign1", 1'b0, 1'b1, 1'b0, 3'd0);
        sym_in(4'd2); chk("lockout_ign2", 1'b0, 1'b1, 1'b0, 3'd0);
        sym_in(4'd3); chk("lockout_ign3", 1'b0, 1'b1, 1'b0, 3'd0);
        sym_in(4'd4); chk("lockout_ign4", 1'b0, 1'b1, 1'b0, 3'd0);
        for (int i = 0; i < 11; i++) begin
            idle(); chk("lockout_hold", 1'b0, 1'b1, 1'b0, 3'd0);
        end
        idle(); chk("lockout_end", 1'b0, 1'b0, 1'b0, 3'd0);
        sym_in(4'd1); chk("accept_after_lockout", 1'b0, 1'b0, 1'b0, 3'd1);
        step(1'b0, 4'd0, 1'b1, 1'b0, 16'h0); chk("clear_entry", 1'b0, 1'b0, 1'b0, 3'd0);

        // reprogram while open
        enter3("open_prefix", 4'd1, 4'd2, 4'd3);
        sym_in(4'd4); chk("open_E", 1'b1, 1'b0, 1'b0, 3'd0);
        step(1'b0, 4'd0, 1'b0, 1'b1, 16'h9876); chk("load_open", 1'b1, 1'b0, 1'b0, 3'd0);
        for (int i = 0; i < 6; i++) begin
            idle(); chk("load_hold", 1'b1, 1'b0, 1'b0, 3'd0);
        end
        idle(); chk("load_close", 1'b0, 1'b0, 1'b0, 3'd0);
        enter3("old_code", 4'd1, 4'd2, 4'd3);
        sym_in(4'd4); chk("old_code_fail", 1'b0, 1'b0, 1'b1, 3'd0);
        enter3("new_code", 4'd6, 4'd7, 4'd8);
        sym_in(4'd9); chk("new_code_open", 1'b1, 1'b0, 1'b0, 3'd0);
        step(1'b0, 4'd0, 1'b1, 1'b1, 16'h4321); chk("load_clear", 1'b0, 1'b0, 1'b0, 3'd0);
        enter3("reload", 4'd1, 4'd2, 4'd3);
        sym_in(4'd4); chk("reload_open", 1'b1, 1'b0, 1'b0, 3'd0);
        step(1'b0, 4'd0, 1'b1, 1'b0, 16'h0); chk("relock", 1'b0, 1'b0, 1'b0, 3'd0);

        // correct entry clears the fail counter
        for (int n = 0; n < 2; n++) begin
            enter3("w2_prefix", 4'd1, 4'd1, 4'd1);
            sym_in(4'd1); chk("w2_fail", 1'b0, 1'b0, 1'b1, 3'd0);
        end
        enter3("mid_ok", 4'd1, 4'd2, 4'd3);
        sym_in(4'd4); chk("mid_ok_open", 1'b1, 1'b0, 1'b0, 3'd0);
        step(1'b0, 4'd0, 1'b1, 1'b0, 16'h0); chk("mid_ok_clear", 1'b0, 1'b0, 1'b0, 3'd0);
        for (int n = 0; n < 2; n++) begin
            enter3("w2b_prefix", 4'd2, 4'd2, 4'd3);
            sym_in(4'd4); chk("w2b_no_lockout", 1'b0, 1'b0, 1'b1, 3'd0);
        end
        enter3("w3_prefix", 4'd0, 4'd2, 4'd3);
        sym_in(4'd4); chk("w3_lockout", 1'b0, 1'b1, 1'b1, 3'd0);
        idle(); chk("lockout_mid", 1'b0, 1'b1, 1'b0, 3'd0);

        // asynchronous reset in lockout, mid-entry and mid-open
        async_reset("reset_lockout");
        chk("post_reset_lockout", 1'b0, 1'b0, 1'b0, 3'd0);
        sym_in(4'd1); chk("pre_reset_entry", 1'b0, 1'b0, 1'b0, 3'd1);
        sym_in(4'd2); chk("pre_reset_entry", 1'b0, 1'b0, 1'b0, 3'd2);
        async_reset("reset_entry");
        enter3("pre_open", 4'd1, 4'd2, 4'd3);
        sym_in(4'd4); chk("pre_open_E", 1'b1, 1'b0, 1'b0, 3'd0);
        step(1'b0, 4'd0, 1'b0, 1'b1, 16'h9876); chk("pre_open_load", 1'b1, 1'b0, 1'b0, 3'd0);
        async_reset("reset_open");
        enter3("code_revert", 4'd1, 4'd2, 4'd3);
        sym_in(4'd4); chk("code_revert_open", 1'b1, 1'b0, 1'b0, 3'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
